mips_cpu_bus_arbiter: RTL and testbench
=======================================

MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

Interface
REQ-001 SHALL: one clock `clk` and one reset `reset`; reset is asynchronous and active-high.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  async active-high reset
- i_address  in  32  instruction-port byte address
- i_read  in  1  instruction-port read request
- i_waitrequest  out  1  instruction-port stall
- i_readdata  out  32  instruction-port read data
- d_address  in  32  data-port byte address
- d_read  in  1  data-port read request
- d_write  in  1  data-port write request
- d_writedata  in  32  data-port write data
- d_byteenable  in  4  data-port byte lanes
- d_waitrequest  out  1  data-port stall
- d_readdata  out  32  data-port read data
- m_address  out  32  shared-bus address to RAM
- m_read  out  1  shared-bus read
- m_write  out  1  shared-bus write
- m_writedata  out  32  shared-bus write data
- m_byteenable  out  4  shared-bus byte lanes
- m_waitrequest  in  1  RAM stall
- m_readdata  in  32  RAM read data, valid in the cycle m_read=1 and m_waitrequest=0

Function
REQ-003 SHALL implement a registered grant FSM with states IDLE, GRANT_I, GRANT_D, plus a 1-bit last_served pointer (I or D).
REQ-004 SHALL define requests: req_i = i_read; req_d = d_read | d_write.
REQ-005 In IDLE SHALL drive m_read=0, m_write=0, m_byteenable=4'b0000, m_address=0, m_writedata=0.
REQ-006 In GRANT_I SHALL drive m_address=i_address, m_read=i_read, m_write=0, m_byteenable=4'b1111, m_writedata=0, combinationally.
REQ-007 In GRANT_D SHALL forward d_address, d_read, d_write, d_writedata, d_byteenable unchanged to the m_* outputs, combinationally.
REQ-008 SHALL drive the granted port's waitrequest = m_waitrequest; the non-granted port's waitrequest = 1; both = 1 in IDLE.
REQ-009 SHALL drive i_readdata and d_readdata = m_readdata at all times; they are meaningful only on the owning port's completion cycle.
REQ-010 SHALL treat a cycle as a completion when the granted port's request is high and m_waitrequest=0; on completion, last_served updates to that port.
REQ-011 IDLE transitions: neither request -> IDLE; one request -> grant it; both -> grant the port not equal to last_served.
REQ-012 Grant latency: a request arriving in IDLE SHALL assert m_read/m_write on the next rising edge (1 cycle).
REQ-013 GRANT_x on completion: other port requesting -> GRANT_other; else same port still requesting -> stay (back-to-back, no idle cycle); else -> IDLE.
REQ-014 GRANT_x while m_waitrequest=1: SHALL hold grant and all forwarded signals; no preemption.
REQ-015 GRANT_x with the granted request deasserted and no completion (abort): SHALL go to GRANT_other if the other port is requesting, else IDLE; last_served unchanged.
REQ-016 d_read and d_write both high is illegal input; the arbiter SHALL forward both unchanged and not check for it.

Reset
REQ-017 While reset=1 SHALL force state=IDLE and last_served=D immediately, without waiting for a clock edge, so the first tie after reset goes to the instruction port.
REQ-018 During reset SHALL drive m_read=0, m_write=0, m_byteenable=0, i_waitrequest=1, d_waitrequest=1, also when reset asserts mid-transfer.
REQ-019 After reset deasserts SHALL take the first grant on the first rising edge at which a request is high.

Verification
REQ-020 Single fetch: i_read=1, i_address=0xBFC00000, m_waitrequest=0 -> next cycle m_read=1, m_address=0xBFC00000, m_byteenable=1111, i_waitrequest=0, i_readdata=m_readdata.
REQ-021 Tie after reset: i_read and d_write (d_address=0x1000, d_writedata=0x00221000, d_byteenable=0011) both high -> I completes first, next cycle m_write=1 with the D values, d_waitrequest=1 until then.
REQ-022 Stall: RAM holds m_waitrequest=1 for 5 cycles during GRANT_D read with i_read pending -> grant, m_address, m_read stable; i_waitrequest=1 throughout; GRANT_I the cycle after D completes.
REQ-023 Fairness: both ports request continuously, m_waitrequest=0 -> grants alternate I,D,I,D with no IDLE cycles.
REQ-024 Async reset mid-transfer: reset rises between clock edges during GRANT_I -> m_read=0 and i_waitrequest=1 at once; after release with both requesting, I is granted first.
REQ-025 Abort: d_read dropped while m_waitrequest=1 and i_read high -> next cycle GRANT_I; last_served unchanged.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter_if.sv
// mips_cpu_bus_arbiter_if
//   Bundles the three Avalon-style ports around the arbiter:
//     i_*  instruction fetch port (read only)
//     d_*  data port (read/write, byte enables)
//     m_*  shared bus toward the RAM
//   modport master : the arbiter's view (owns the waitrequests, readdata and m_* drive)
//   modport slave  : the environment's view (CPU ports and RAM)
interface mips_cpu_bus_arbiter_if;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;

  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;

  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  modport master (
    input  i_address, i_read,
    output i_waitrequest, i_readdata,
    input  d_address, d_read, d_write, d_writedata, d_byteenable,
    output d_waitrequest, d_readdata,
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata
  );

  modport slave (
    output i_address, i_read,
    input  i_waitrequest, i_readdata,
    output d_address, d_read, d_write, d_writedata, d_byteenable,
    input  d_waitrequest, d_readdata,
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata
  );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter
//   Shares one RAM bus between the instruction and data ports of a MIPS core.
//   A registered grant FSM (IDLE / GRANT_I / GRANT_D) picks the owner; the
//   owner's request is forwarded combinationally to the m_* side. Ties are
//   broken against the last port that completed a transfer.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high
//     bus    mips_cpu_bus_arbiter_if.master (i_*, d_*, m_* signals)
module mips_cpu_bus_arbiter (
  input  logic                          clk,
  input  logic                          reset,
  mips_cpu_bus_arbiter_if.master        bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t state_q, state_d;
  // 1 = data port completed last, 0 = instruction port
  logic   last_d_q, last_d_d;

  logic req_i, req_d;

  logic [31:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        i_wait, d_wait;

  assign req_i = bus.i_read;
  assign req_d = bus.d_read | bus.d_write;

  // Reset to last=D so the first tie goes to instruction fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    m_address    = 32'h0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = 32'h0;
    m_byteenable = 4'b0000;
    i_wait       = 1'b1;
    d_wait       = 1'b1;

    case (state_q)
      IDLE: begin
        if (req_i && req_d) state_d = last_d_q ? GRANT_I : GRANT_D;
        else if (req_i)     state_d = GRANT_I;
        else if (req_d)     state_d = GRANT_D;
      end

      GRANT_I: begin
        m_address    = bus.i_address;
        m_read       = bus.i_read;
        m_byteenable = 4'b1111;
        i_wait       = bus.m_waitrequest;
        if (!req_i) begin
          // abort: hand over without touching last_d
          state_d = req_d ? GRANT_D : IDLE;
        end else if (!bus.m_waitrequest) begin
          last_d_d = 1'b0;
          state_d  = req_d ? GRANT_D : GRANT_I;
        end
      end

      GRANT_D: begin
        m_address    = bus.d_address;
        m_read       = bus.d_read;
        m_write      = bus.d_write;
        m_writedata  = bus.d_writedata;
        m_byteenable = bus.d_byteenable;
        d_wait       = bus.m_waitrequest;
        if (!req_d) begin
          state_d = req_i ? GRANT_I : IDLE;
        end else if (!bus.m_waitrequest) begin
          last_d_d = 1'b1;
          state_d  = req_i ? GRANT_I : GRANT_D;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.m_address     = m_address;
  assign bus.m_read        = m_read;
  assign bus.m_write       = m_write;
  assign bus.m_writedata   = m_writedata;
  assign bus.m_byteenable  = m_byteenable;
  assign bus.i_waitrequest = i_wait;
  assign bus.d_waitrequest = d_wait;
  assign bus.i_readdata    = bus.m_readdata;
  assign bus.d_readdata    = bus.m_readdata;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
module tb_mips_cpu_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_bus_arbiter_if bus ();

  mips_cpu_bus_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] IADDR = 32'hBFC0_0000;
  localparam logic [31:0] DADDR = 32'h0000_1000;
  localparam logic [31:0] DDATA = 32'h0022_1000;
  localparam logic [3:0]  DBE   = 4'b0011;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw, input logic mw);
    bus.i_read = ir; bus.d_read = dr; bus.d_write = dw; bus.m_waitrequest = mw;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    bus.i_address = IADDR; bus.d_address = DADDR;
    bus.d_writedata = DDATA; bus.d_byteenable = DBE;
    bus.m_readdata = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // owner: 0 none, 1 instruction, 2 data
  int   owner;
  logic last_i;

  typedef struct {
    logic ir, dr, dw, mw;
    logic emr, emw, eiw, edw;
    logic [31:0] eaddr;
  } vec_t;
  vec_t tbl [7];

  initial begin
    // tie after reset, continuous contention, then both drop
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, IADDR};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, DADDR};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, IADDR};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, DADDR};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, IADDR};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};

    bus.i_address = IADDR; bus.d_address = DADDR;
    bus.d_writedata = DDATA; bus.d_byteenable = DBE;
    bus.m_readdata = 32'h0; drive(0, 0, 0, 0);
    #2;
    chk("reset m_read", bus.m_read, 0);
    chk("reset m_write", bus.m_write, 0);
    chk("reset m_be", bus.m_byteenable, 0);
    chk("reset i_wait", bus.i_waitrequest, 1);
    chk("reset d_wait", bus.d_waitrequest, 1);

    // ---- table vectors
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(tbl[k].ir, tbl[k].dr, tbl[k].dw, tbl[k].mw);
      #1;
      chk($sformatf("tbl%0d m_read", k), bus.m_read, tbl[k].emr);
      chk($sformatf("tbl%0d m_write", k), bus.m_write, tbl[k].emw);
      chk($sformatf("tbl%0d i_wait", k), bus.i_waitrequest, tbl[k].eiw);
      chk($sformatf("tbl%0d d_wait", k), bus.d_waitrequest, tbl[k].edw);
      chk($sformatf("tbl%0d m_addr", k), bus.m_address, tbl[k].eaddr);
      if (k == 2) begin
        chk("tbl2 m_wdata", bus.m_writedata, DDATA);
        chk("tbl2 m_be", bus.m_byteenable, {28'h0, DBE});
      end
      @(negedge clk);
    end

    // ---- single fetch
    do_reset();
    drive(1, 0, 0, 0); bus.m_readdata = 32'h1234_5678;
    #1 chk("fetch idle m_read", bus.m_read, 0);
    @(negedge clk); #1;
    chk("fetch m_read", bus.m_read, 1);
    chk("fetch m_addr", bus.m_address, IADDR);
    chk("fetch m_be", bus.m_byteenable, 32'hF);
    chk("fetch i_wait", bus.i_waitrequest, 0);
    chk("fetch i_rdata", bus.i_readdata, 32'h1234_5678);

    // ---- stall during data read with fetch pending
    do_reset();
    bus.d_address = 32'h2000;
    drive(0, 1, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d m_read", k), bus.m_read, 1);
      chk($sformatf("stall%0d m_addr", k), bus.m_address, 32'h2000);
      chk($sformatf("stall%0d i_wait", k), bus.i_waitrequest, 1);
      chk($sformatf("stall%0d d_wait", k), bus.d_waitrequest, 1);
      @(negedge clk);
    end
    drive(1, 1, 0, 0);
    #1 chk("stall done d_wait", bus.d_waitrequest, 0);
    @(negedge clk); drive(1, 0, 0, 0); #1;
    chk("stall then I addr", bus.m_address, IADDR);
    chk("stall then I i_wait", bus.i_waitrequest, 0);

    // ---- async reset mid-transfer
    do_reset();
    drive(1, 0, 0, 0);
    @(negedge clk); #1 chk("areset pre m_read", bus.m_read, 1);
    #1 reset = 1'b1;
    #1;
    chk("areset m_read", bus.m_read, 0);
    chk("areset m_be", bus.m_byteenable, 0);
    chk("areset i_wait", bus.i_waitrequest, 1);
    chk("areset d_wait", bus.d_waitrequest, 1);
    drive(1, 1, 0, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    chk("areset tie addr", bus.m_address, IADDR);
    chk("areset tie i_wait", bus.i_waitrequest, 0);

    // ---- abort keeps last_served
    do_reset();
    drive(1, 0, 0, 0);
    @(negedge clk); drive(1, 1, 0, 0);         // I completes -> last=I
    @(negedge clk); drive(1, 1, 0, 1);         // D stalls
    @(negedge clk); drive(1, 0, 0, 1);         // D aborts
    @(negedge clk); #1;
    chk("abort -> I addr", bus.m_address, IADDR);
    chk("abort -> I m_read", bus.m_read, 1);
    drive(0, 0, 0, 1);                          // I aborts -> IDLE
    @(negedge clk); #1;
    chk("abort idle m_read", bus.m_read, 0);
    drive(1, 1, 0, 0);
    @(negedge clk); #1;
    chk("abort tie -> D addr", bus.m_address, DADDR);
    chk("abort tie d_wait", bus.d_waitrequest, 0);

    // ---- randomized against reference model
    do_reset();
    owner = 0; last_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ea, ew; logic er, ewr, eiw, edw; logic [3:0] ebe;
      bus.i_read = ($urandom_range(0, 9) < 6);
      bus.d_read = ($urandom_range(0, 9) < 4);
      bus.d_write = ($urandom_range(0, 9) < 3);
      bus.m_waitrequest = ($urandom_range(0, 9) < 3);
      bus.i_address = $urandom; bus.d_address = $urandom;
      bus.d_writedata = $urandom; bus.d_byteenable = 4'($urandom);
      bus.m_readdata = $urandom;
      #1;
      ea = 0; ew = 0; er = 0; ewr = 0; ebe = 0; eiw = 1; edw = 1;
      if (owner == 1) begin
        ea = bus.i_address; er = bus.i_read; ebe = 4'hF; eiw = bus.m_waitrequest;
      end else if (owner == 2) begin
        ea = bus.d_address; er = bus.d_read; ewr = bus.d_write;
        ew = bus.d_writedata; ebe = bus.d_byteenable; edw = bus.m_waitrequest;
      end
      chk($sformatf("rnd%0d m_addr", c), bus.m_address, ea);
      chk($sformatf("rnd%0d m_read", c), bus.m_read, er);
      chk($sformatf("rnd%0d m_write", c), bus.m_write, ewr);
      chk($sformatf("rnd%0d m_wdata", c), bus.m_writedata, ew);
      chk($sformatf("rnd%0d m_be", c), bus.m_byteenable, ebe);
      chk($sformatf("rnd%0d i_wait", c), bus.i_waitrequest, eiw);
      chk($sformatf("rnd%0d d_wait", c), bus.d_waitrequest, edw);
      chk($sformatf("rnd%0d i_rdata", c), bus.i_readdata, bus.m_readdata);
      chk($sformatf("rnd%0d d_rdata", c), bus.d_readdata, bus.m_readdata);
      @(posedge clk);
      begin
        logic ri, rd, mine, others;
        ri = bus.i_read; rd = bus.d_read | bus.d_write;
        if (owner == 0) begin
          if (ri && rd) owner = last_i ? 2 : 1;
          else if (ri)  owner = 1;
          else if (rd)  owner = 2;
        end else begin
          mine   = (owner == 1) ? ri : rd;
          others = (owner == 1) ? rd : ri;
          if (!(mine && bus.m_waitrequest)) begin
            if (mine) last_i = (owner == 1);
            if (others)     owner = 3 - owner;
            else if (!mine) owner = 0;
          end
        end
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
